// File: rtl/minisys_pkg.sv
// Shared Minisys definitions: opcodes,
// fetch-state encoding and reset vector.
package minisys_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/npc_calc32.sv
// Combinational next-PC selection for the
// fetch unit, plus jr target alignment check.
module npc_calc32
  import minisys_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_lo,
  input  logic [31:0] rd1,
  input  logic        branch,
  input  logic        nbranch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jrn,
  input  logic        zero,
  output logic [31:0] pc4,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        take;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{instr_lo[15]}},
                   instr_lo[15:0], 2'b00};
  assign br_tgt = pc4 + br_off;
  assign j_tgt  = {pc4[31:28], instr_lo, 2'b00};
  assign take   = (branch & zero) |
                  (nbranch & ~zero);

  assign misalign = jrn & (|rd1[1:0]);

  // jr beats j/jal beats taken branch
  always_comb begin
    npc = pc4;
    if (jrn)
      npc = rd1;
    else if (jmp | jal)
      npc = j_tgt;
    else if (take)
      npc = br_tgt;
  end

endmodule

// File: rtl/ifetch_seq32.sv
// Sequential fetch unit: owns the PC, fetches
// one word, holds it until execute retires it.
module ifetch_seq32
  import minisys_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            Instruction,
  output logic [5:0]             Opcode,
  output logic [5:0]             Function_opcode,
  output logic                   inst_valid,
  input  logic                   exec_done,
  input  logic                   Branch,
  input  logic                   nBranch,
  input  logic                   Jmp,
  input  logic                   Jal,
  input  logic                   Jrn,
  input  logic                   Zero,
  input  logic [31:0]            Read_data_1,
  output logic [31:0]            pco,
  output logic [31:0]            link_addr,
  output logic                   misalign_err
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  npc;
  logic         misalign;
  logic         ld_pc;
  logic         ld_ir;
  logic         set_err;

  npc_calc32 u_npc (
    .pc       (pco),
    .instr_lo (Instruction[25:0]),
    .rd1      (Read_data_1),
    .branch   (Branch),
    .nbranch  (nBranch),
    .jmp      (Jmp),
    .jal      (Jal),
    .jrn      (Jrn),
    .zero     (Zero),
    .pc4      (link_addr),
    .npc      (npc),
    .misalign (misalign)
  );

  assign imem_addr       = pco[IMEM_ADDR_W+1:2];
  assign Opcode          = Instruction[31:26];
  assign Function_opcode = Instruction[5:0];

  always_comb begin
    state_d = state_q;
    ld_pc   = 1'b0;
    ld_ir   = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          state_d = S_HOLD;
          ld_ir   = 1'b1;
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          if (misalign) begin
            state_d = S_HALT;
            set_err = 1'b1;
          end else begin
            state_d = S_REQ;
            ld_pc   = 1'b1;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake outputs decode the next state
  // so they are flop outputs, not comb logic
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      pco          <= RESET_PC;
      Instruction  <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req   <= (state_d == S_REQ);
      inst_valid <= (state_d == S_HOLD);
      if (ld_pc)
        pco <= npc;
      if (ld_ir)
        Instruction <= imem_rdata;
      if (set_err)
        misalign_err <= 1'b1;
    end
  end

endmodule
